// File: rtl/fx2_mux_writer.sv
// Round-robin multiplexer that drains N_CH show-ahead FIFOs into an FX2 slave FIFO.
// Each burst is one header word {4'hA, channel, length} followed by up to MAX_BURST data words.
module fx2_mux_writer #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned PKT_WORDS = 256,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [1:0]  EP_ADDR   = 2'b10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [N_CH*8-1:0]  ch_usedw,
  input  logic [N_CH*16-1:0] ch_q,
  output logic [N_CH-1:0]    ch_rdrq,
  input  logic               FLAG_FULL,
  output logic [15:0]        FD,
  output logic               SLWR,
  output logic               SLRD,
  output logic               SLOE,
  output logic               PKTEND,
  output logic [1:0]         FIFOADR
);

  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned WcW = $clog2(PKT_WORDS + 1);
  localparam int unsigned IcW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StArb, StHdr, StData, StCommit} state_e;

  state_e         state_q, state_d;
  logic [ChW-1:0] ptr_q, ptr_d, grant_q, grant_d, arb_ch, arb_idx;
  logic [7:0]     len_q, len_d, remain_q, remain_d, arb_len;
  logic [WcW-1:0] wcnt_q, wcnt_d;
  logic [IcW-1:0] idle_q, idle_d;
  logic [15:0]    fd_q, fd_d;
  logic           slwr_q, slwr_d, pktend_q, pktend_d;
  logic           arb_hit, any_data, pop, tmo;

  logic [7:0]  usedw [N_CH];
  logic [15:0] head  [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign usedw[c] = ch_usedw[c*8 +: 8];
    assign head[c]  = ch_q[c*16 +: 16];
  end

  assign any_data = |ch_usedw;
  assign pop      = (state_q == StData) && FLAG_FULL && (remain_q != 8'd0);
  assign tmo      = (state_q == StIdle) && FLAG_FULL && (wcnt_q != '0) &&
                    (idle_q >= IcW'(TIMEOUT));

  // Scan downwards so the lowest offset from ptr+1 wins without a break.
  always_comb begin
    arb_hit = 1'b0;
    arb_ch  = ptr_q;
    arb_idx = '0;
    for (int i = N_CH; i >= 1; i--) begin
      arb_idx = ChW'((int'(ptr_q) + i) % N_CH);
      if (usedw[arb_idx] != 8'd0) begin
        arb_hit = 1'b1;
        arb_ch  = arb_idx;
      end
    end
    arb_len = (usedw[arb_ch] > 8'(MAX_BURST)) ? 8'(MAX_BURST) : usedw[arb_ch];
  end

  always_comb begin
    ch_rdrq = '0;
    if (pop) ch_rdrq[grant_q] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (tmo)                 state_d = StCommit;
        else if (EN && any_data) state_d = StArb;
      end
      StArb:    state_d = arb_hit ? StHdr : StIdle;
      StHdr:    if (FLAG_FULL) state_d = StData;
      StData:   if (remain_q == 8'd0 || (pop && remain_q == 8'd1)) state_d = StIdle;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    len_d    = len_q;
    remain_d = remain_q;
    wcnt_d   = wcnt_q;
    idle_d   = idle_q;
    fd_d     = fd_q;
    slwr_d   = 1'b1;
    pktend_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (tmo) pktend_d = 1'b0;
        if (wcnt_q != '0 && idle_q != IcW'(TIMEOUT)) idle_d = idle_q + IcW'(1);
      end
      StArb: begin
        if (arb_hit) begin
          grant_d  = arb_ch;
          len_d    = arb_len;
          remain_d = arb_len;
        end
      end
      StHdr: begin
        if (FLAG_FULL) begin
          fd_d   = {4'hA, 4'(grant_q), len_q};
          slwr_d = 1'b0;
        end
      end
      StData: begin
        if (pop) begin
          fd_d     = head[grant_q];
          slwr_d   = 1'b0;
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) ptr_d = grant_q;
        end
      end
      StCommit: begin
        wcnt_d = '0;
        idle_d = '0;
      end
      default: ;
    endcase
    // A full packet is committed by the FX2 itself, so the count just wraps.
    if (!slwr_d) begin
      idle_d = '0;
      wcnt_d = (wcnt_q == WcW'(PKT_WORDS - 1)) ? '0 : wcnt_q + WcW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q    <= ChW'(N_CH - 1);
      grant_q  <= '0;
      len_q    <= '0;
      remain_q <= '0;
      wcnt_q   <= '0;
      idle_q   <= '0;
      fd_q     <= '0;
      slwr_q   <= 1'b1;
      pktend_q <= 1'b1;
    end else begin
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      len_q    <= len_d;
      remain_q <= remain_d;
      wcnt_q   <= wcnt_d;
      idle_q   <= idle_d;
      fd_q     <= fd_d;
      slwr_q   <= slwr_d;
      pktend_q <= pktend_d;
    end
  end

  assign FD      = fd_q;
  assign SLWR    = slwr_q;
  assign PKTEND  = pktend_q;
  assign SLRD    = 1'b1;
  assign SLOE    = 1'b1;
  assign FIFOADR = EP_ADDR;

endmodule

// File: tb/tb_fx2_mux_writer.sv
// Directed bench for fx2_mux_writer: expected FX2 words queue up at stimulus time and
// a negedge monitor pops and compares them whenever SLWR is low.
module tb_fx2_mux_writer;

  localparam int NCh     = 4;
  localparam int Timeout = 16;

  logic              CLK, RST, EN, FLAG_FULL;
  logic [NCh*8-1:0]  ch_usedw;
  logic [NCh*16-1:0] ch_q;
  logic [NCh-1:0]    ch_rdrq;
  logic [15:0]       FD;
  logic              SLWR, SLRD, SLOE, PKTEND;
  logic [1:0]        FIFOADR;

  fx2_mux_writer #(
    .N_CH(NCh), .MAX_BURST(16), .PKT_WORDS(32), .TIMEOUT(Timeout), .EP_ADDR(2'b10)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .ch_usedw(ch_usedw), .ch_q(ch_q), .ch_rdrq(ch_rdrq),
    .FLAG_FULL(FLAG_FULL), .FD(FD), .SLWR(SLWR), .SLRD(SLRD), .SLOE(SLOE),
    .PKTEND(PKTEND), .FIFOADR(FIFOADR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, wr_cnt = 0, pk_cnt = 0, pk_cyc = 0, last_wr_cyc = 0;
  int rd_cnt [NCh];
  logic [15:0] mem [NCh][$];
  logic [15:0] exp_q [$];
  logic [7:0]  usedw_r [NCh];
  logic [15:0] head_r  [NCh];
  logic        ff_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source FIFO model: show-ahead head and fill level, updated after each pop edge.
  initial for (int c = 0; c < NCh; c++) begin
    rd_cnt[c] = 0; usedw_r[c] = '0; head_r[c] = '0;
  end
  always @(posedge CLK) begin
    cyc++;
    for (int c = 0; c < NCh; c++) begin
      if (ch_rdrq[c]) begin
        rd_cnt[c]++;
        check("pop_nonempty", mem[c].size() != 0, 1);
        if (mem[c].size() != 0) void'(mem[c].pop_front());
      end
      usedw_r[c] <= 8'(mem[c].size());
      head_r[c]  <= (mem[c].size() != 0) ? mem[c][0] : 16'h0;
    end
  end
  always_comb begin
    ch_usedw = '0;
    ch_q     = '0;
    for (int c = 0; c < NCh; c++) begin
      ch_usedw[c*8 +: 8] = usedw_r[c];
      ch_q[c*16 +: 16]   = head_r[c];
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      if (!SLWR) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got %0h expected none", FD);
        end else begin
          check("fd_word", FD, exp_q.pop_front());
        end
      end
      if (!PKTEND) begin
        pk_cnt++;
        pk_cyc = cyc;
        check("pktend_with_slwr", SLWR, 1);
      end
      if (!FLAG_FULL) check("rdrq_while_full", ch_rdrq, 0);
      if (!ff_prev)   check("slwr_after_full", SLWR, 1);
      if (ch_rdrq != '0) check("rdrq_onehot", $countones(ch_rdrq), 1);
      ff_prev = FLAG_FULL;
    end
  end

  task automatic load(input int c, input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) mem[c].push_back(base + 16'(k));
  endtask

  task automatic expect_burst(input int c, input int len, input logic [15:0] first);
    exp_q.push_back({4'hA, 4'(c), 8'(len)});
    for (int k = 0; k < len; k++) exp_q.push_back(first + 16'(k));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge CLK); n++; end
    check(name, exp_q.size(), 0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic wait_rdrq(input int c, input string name);
    int n = 0;
    while (ch_rdrq[c] !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    check(name, ch_rdrq[c], 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fd"}, FD, 16'h0);
    check({tag, "_slwr"}, SLWR, 1);
    check({tag, "_pktend"}, PKTEND, 1);
    check({tag, "_rdrq"}, ch_rdrq, 0);
    check({tag, "_slrd"}, SLRD, 1);
    check({tag, "_sloe"}, SLOE, 1);
    check({tag, "_fifoadr"}, FIFOADR, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pk0, wr0, rd0, d;
    RST = 1'b0; EN = 1'b1; FLAG_FULL = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("reset");
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // All channels 40 deep: ch0..ch3 twice with len 16, then len 8 each.
    pk0 = pk_cnt;
    for (int c = 0; c < NCh; c++) load(c, 40, 16'(c << 12));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NCh; c++)
        expect_burst(c, (r < 2) ? 16 : 8, 16'(c << 12) + 16'(r * 16));
    wait_drain("rr_drain");
    repeat (Timeout + 10) @(posedge CLK);
    #1 check("rr_commit_count", pk_cnt - pk0, 1);

    // ch1 with 3 words: header A103, 3 pops, then one timeout commit.
    pk0 = pk_cnt; wr0 = wr_cnt; rd0 = rd_cnt[1];
    load(1, 3, 16'h1111);
    expect_burst(1, 3, 16'h1111);
    wait_drain("ch1_drain");
    check("ch1_writes", wr_cnt - wr0, 4);
    check("ch1_pops", rd_cnt[1] - rd0, 3);
    repeat (Timeout + 10) @(posedge CLK);
    #1 check("timeout_commit_count", pk_cnt - pk0, 1);
    d = pk_cyc - last_wr_cyc;
    check("timeout_delay", (d >= Timeout) && (d <= Timeout + 2), 1);

    // Exactly 32 words wraps the packet count: no PKTEND afterwards.
    pk0 = pk_cnt;
    load(2, 30, 16'h2200);
    expect_burst(2, 16, 16'h2200);
    expect_burst(2, 14, 16'h2210);
    wait_drain("full_pkt_drain");
    repeat (Timeout + 10) @(posedge CLK);
    #1 check("full_pkt_no_commit", pk_cnt - pk0, 0);

    // FLAG_FULL low for 5 cycles in the middle of a burst.
    pk0 = pk_cnt; rd0 = rd_cnt[3];
    load(3, 10, 16'h3300);
    expect_burst(3, 10, 16'h3300);
    wait_rdrq(3, "stall_start");
    repeat (2) @(posedge CLK);
    #1 FLAG_FULL = 1'b0;
    repeat (5) @(posedge CLK);
    #1 FLAG_FULL = 1'b1;
    wait_drain("stall_drain");
    check("stall_pops", rd_cnt[3] - rd0, 10);
    repeat (Timeout + 10) @(posedge CLK);
    #1 check("stall_commit_count", pk_cnt - pk0, 1);

    // EN dropped during ch0's burst: it completes, ch1 waits, timeout still commits.
    pk0 = pk_cnt; wr0 = wr_cnt; rd0 = rd_cnt[1];
    load(0, 12, 16'h4400);
    load(1, 5, 16'h5500);
    expect_burst(0, 12, 16'h4400);
    wait_rdrq(0, "en_burst_start");
    @(posedge CLK);
    #1 EN = 1'b0;
    repeat (40) @(posedge CLK);
    #1 check("en_burst_done", exp_q.size(), 0);
    check("en_writes", wr_cnt - wr0, 13);
    check("en_no_ch1", rd_cnt[1] - rd0, 0);
    check("en_commit_count", pk_cnt - pk0, 1);
    expect_burst(1, 5, 16'h5500);
    EN = 1'b1;
    wait_drain("en_resume_drain");

    // Reset with 7 words left: burst abandoned, new header re-reads usedw.
    load(2, 12, 16'h7000);
    exp_q.push_back(16'hA20C);
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h7000 + 16'(k));
    wait_rdrq(2, "rst_burst_start");
    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    #1 check_reset_outputs("midrst");
    check("midrst_seen", exp_q.size(), 0);
    rd0 = rd_cnt[2];
    repeat (3) @(posedge CLK);
    #1 check("midrst_no_pop", rd_cnt[2] - rd0, 0);
    expect_burst(2, 7, 16'h7005);
    RST = 1'b1;
    wait_drain("midrst_resume_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
